mem_arbiter: RTL and testbench

- Single-port arbiter and sequencer that shares one unified, word-addressed instruction/data memory between two requesters: the IF stage (instruction fetch) and the MEM stage (LDR/STR).
- Holds the memory address and controls stable for MEM_LATENCY cycles and captures read data at the end of that window.
- Drives a freeze signal that stalls the pipeline until each access completes.
- Sits between the pipeline stages and the memory array that replaces the separate instruction ROM and data RAM.

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one word-addressed memory between instruction fetch and the load/store stage.
// Data accesses win arbitration; each grant holds the address stable for MEM_LATENCY cycles.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        dm_rd_en,
  input  logic        dm_wr_en,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        freeze
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             owner_reg;   // 0 = fetch, 1 = data
  logic             wr_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      if_inst_reg;
  logic [31:0]      dm_rdata_reg;
  logic             dm_req;

  assign dm_req = dm_rd_en | dm_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      owner_reg    <= 1'b0;
      wr_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      if_inst_reg  <= '0;
      dm_rdata_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Data request is from the older instruction, so it goes first.
          if (dm_req) begin
            owner_reg <= 1'b1;
            addr_reg  <= {dm_addr[31:2], 2'b00};
            wdata_reg <= dm_wdata;
            wr_reg    <= dm_wr_en;
            cnt_reg   <= CNT_LOAD;
            state_reg <= S_ACCESS;
          end else if (if_req) begin
            owner_reg <= 1'b0;
            addr_reg  <= {if_addr[31:2], 2'b00};
            wdata_reg <= dm_wdata;
            wr_reg    <= dm_wr_en;
            cnt_reg   <= CNT_LOAD;
            state_reg <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            if (owner_reg) dm_rdata_reg <= mem_rdata;
            else           if_inst_reg  <= mem_rdata;
            state_reg <= S_DONE;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = (state_reg == S_ACCESS);
  assign mem_we    = mem_en & wr_reg & owner_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign if_ready  = (state_reg == S_DONE) & ~owner_reg;
  assign dm_ready  = (state_reg == S_DONE) & owner_reg;
  assign if_inst   = if_inst_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign freeze    = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter with a golden memory image
// plus two extra instances for latency sweep.
module tb_mem_arbiter;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, dm_rd_en, dm_wr_en;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_inst, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, freeze;

  mem_arbiter #(.MEM_LATENCY(L), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_ready(if_ready),
    .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .freeze(freeze)
  );

  logic [31:0] gold [512];
  logic [31:0] ram  [512];
  logic        load_en;
  int          wr_cnt = 0;

  assign mem_rdata = ram[mem_addr[10:2]];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 512; i++) ram[i] <= gold[i];
    end else if (mem_en && mem_we) begin
      ram[mem_addr[10:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Latency sweep instances: MEM_LATENCY 1 and 8, fetch only.
  logic        sw_req   [2];
  logic [31:0] sw_addr  [2];
  logic [31:0] sw_inst  [2];
  logic        sw_ready [2];
  logic [31:0] sw_rdata [2];
  logic        sw_dmrdy [2];
  logic        sw_en    [2];
  logic        sw_we    [2];
  logic [31:0] sw_maddr [2];
  logic [31:0] sw_wdata [2];
  logic [31:0] sw_mrd   [2];
  logic        sw_frz   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    assign sw_mrd[gi] = sw_maddr[gi] ^ 32'h5A5A_0000;
    mem_arbiter #(.MEM_LATENCY(gi == 0 ? 1 : 8), .CNT_W(4)) u_sw (
      .clk(clk), .rst(rst),
      .if_req(sw_req[gi]), .if_addr(sw_addr[gi]), .if_inst(sw_inst[gi]), .if_ready(sw_ready[gi]),
      .dm_rd_en(1'b0), .dm_wr_en(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_rdata(sw_rdata[gi]), .dm_ready(sw_dmrdy[gi]),
      .mem_en(sw_en[gi]), .mem_we(sw_we[gi]), .mem_addr(sw_maddr[gi]), .mem_wdata(sw_wdata[gi]),
      .mem_rdata(sw_mrd[gi]), .freeze(sw_frz[gi])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One requester-level transaction; requests are held until their ready pulse.
  task automatic txn(input bit wi, input bit rd, input bit wr, input logic [31:0] ia,
                     input logic [31:0] da, input logic [31:0] wd, input bit drop);
    bit          dmq, pif, pdm, in_dm, in_if;
    int          tdm, tif, kend, w0;
    logic [31:0] dexp, iexp;
    dmq  = rd | wr;
    tdm  = dmq ? L + 1 : -1;
    tif  = wi ? (dmq ? 2 * L + 3 : L + 1) : -1;
    kend = (tif > tdm) ? tif : tdm;
    dexp = gold[da[10:2]];
    if (wr) gold[da[10:2]] = wd;
    iexp = gold[ia[10:2]];
    w0   = wr_cnt;
    if_req = wi; if_addr = ia; dm_rd_en = rd; dm_wr_en = wr; dm_addr = da; dm_wdata = wd;
    pif = wi; pdm = dmq;
    #1;
    chk("freeze_t0", {31'b0, freeze}, {31'b0, pif | pdm});
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk); #1;
      in_dm = dmq && k >= 1 && k <= L;
      in_if = wi && (dmq ? (k >= L + 3 && k <= 2 * L + 2) : (k >= 1 && k <= L));
      chk("if_ready", {31'b0, if_ready}, {31'b0, k == tif});
      chk("dm_ready", {31'b0, dm_ready}, {31'b0, k == tdm});
      chk("freeze",   {31'b0, freeze},   {31'b0, (pif && k != tif) || (pdm && k != tdm)});
      chk("mem_en",   {31'b0, mem_en},   {31'b0, in_dm | in_if});
      chk("mem_we",   {31'b0, mem_we},   {31'b0, in_dm & wr});
      if (in_dm) chk("mem_addr_dm", mem_addr, {da[31:2], 2'b00});
      if (in_if) chk("mem_addr_if", mem_addr, {ia[31:2], 2'b00});
      if (in_dm && wr) chk("mem_wdata", mem_wdata, wd);
      if (k == tdm) begin
        if (!wr) chk("dm_rdata", dm_rdata, dexp);
        dm_rd_en = 1'b0; dm_wr_en = 1'b0; pdm = 1'b0;
      end
      if (k == tif) begin
        chk("if_inst", if_inst, iexp);
        if_req = 1'b0; pif = 1'b0;
      end
      if (drop && k == 1) begin
        if_req = 1'b0; pif = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("idle_en",  {31'b0, mem_en},   32'd0);
    chk("idle_rdy", {31'b0, if_ready | dm_ready}, 32'd0);
    chk("idle_frz", {31'b0, freeze},   32'd0);
    chk("wr_count", wr_cnt - w0, wr ? L : 0);
    $display("txn if=%0b rd=%0b wr=%0b drop=%0b ia=%h da=%h wd=%h checks=%0d errors=%0d",
             wi, rd, wr, drop, ia, da, wd, checks, errors);
  endtask

  task automatic sweep(input int i, input int lat, input logic [31:0] a);
    int k, en_n;
    bit seen;
    k = 0; en_n = 0; seen = 1'b0;
    sw_addr[i] = a; sw_req[i] = 1'b1;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (sw_en[i]) begin
        en_n++;
        chk("sweep_addr", sw_maddr[i], {a[31:2], 2'b00});
      end
      if (sw_ready[i]) begin
        seen = 1'b1;
        chk("sweep_inst", sw_inst[i], {a[31:2], 2'b00} ^ 32'h5A5A_0000);
        sw_req[i] = 1'b0;
      end
    end
    chk("sweep_lat", k, lat + 1);
    chk("sweep_hold", en_n, lat);
    sw_req[i] = 1'b0;
    @(posedge clk); #1;
    $display("sweep lat=%0d addr=%h ready_after=%0d hold=%0d", lat, a, k, en_n);
  endtask

  initial begin
    int          kind;
    logic [31:0] ia, da, wd;
    int          w0;
    rst = 1'b1; load_en = 1'b1;
    if_req = 0; dm_rd_en = 0; dm_wr_en = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
    sw_req[0] = 0; sw_req[1] = 0; sw_addr[0] = 0; sw_addr[1] = 0;
    for (int i = 0; i < 512; i++) gold[i] = $urandom;
    gold[1] = 32'hE3A0_0014;
    @(posedge clk); #1;
    load_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_en",    {31'b0, mem_en}, 32'd0);
    chk("rst_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_inst",  if_inst, 32'd0);
    chk("rst_rdata", dm_rdata, 32'd0);
    chk("rst_rdy",   {31'b0, if_ready | dm_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    txn(1, 0, 0, 32'h0000_0006, 32'h0, 32'h0, 0);
    txn(0, 0, 1, 32'h0, 32'h0000_0400, 32'h0000_2000, 0);
    txn(0, 1, 0, 32'h0, 32'h0000_0400, 32'h0, 0);
    txn(1, 1, 0, 32'h0000_0010, 32'h0000_0400, 32'h0, 0);
    txn(1, 0, 0, 32'h0000_0024, 32'h0, 32'h0, 1);
    txn(0, 1, 1, 32'h0, 32'h0000_0088, 32'hCAFE_F00D, 0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      ia = $urandom; da = $urandom; wd = $urandom;
      case (kind)
        0: txn(1, 0, 0, ia, da, wd, 1'($urandom_range(0, 1)));
        1: txn(0, 1, 0, ia, da, wd, 0);
        2: txn(0, 0, 1, ia, da, wd, 0);
        3: txn(0, 1, 1, ia, da, wd, 0);
        4: txn(1, 1, 0, ia, da, wd, 0);
        default: txn(1, 0, 1, ia, da, wd, 0);
      endcase
    end

    // Reset mid-write: the first ACCESS cycle's write lands, nothing after.
    w0 = wr_cnt;
    dm_wr_en = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("pre_rst_we", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_mid_we",  {31'b0, mem_we}, 32'd0);
      chk("rst_mid_en",  {31'b0, mem_en}, 32'd0);
      chk("rst_mid_rdy", {31'b0, if_ready | dm_ready}, 32'd0);
    end
    rst = 1'b0; dm_wr_en = 1'b0;
    gold[64] = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_en",  {31'b0, mem_en}, 32'd0);
      chk("post_rst_rdy", {31'b0, if_ready | dm_ready}, 32'd0);
    end
    chk("rst_writes", wr_cnt - w0, 32'd1);
    chk("post_rst_inst", if_inst, 32'd0);
    $display("txn reset-abort writes=%0d checks=%0d errors=%0d", wr_cnt - w0, checks, errors);
    txn(0, 1, 0, 32'h0, 32'h0000_0100, 32'h0, 0);

    sweep(0, 1, 32'h0000_0ABE);
    sweep(1, 8, 32'h1234_5673);
    sweep(0, 1, $urandom);
    sweep(1, 8, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
